// File: rtl/osc_trim_sar.sv
`default_nettype none
//==============================================================================
// Module   : osc_trim_sar
// Brief    : SAR oscillator trim engine with optional closed-loop +/-1 tracking,
//            measuring osc_clk cycles per (ref_div+1) reference periods.
// Revision : 1.0
//==============================================================================
module osc_trim_sar #(
    parameter int TRIM_W = 16,
    parameter int CNT_W  = 16,
    parameter int DIV_W  = 8,
    parameter int POL    = 1,
    parameter int SETTLE = 1
) (
    input  logic              osc_clk,
    input  logic              rstb,
    input  logic              ref_clk_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              mode_i,
    input  logic [3:0]        from_msb_i,
    input  logic [DIV_W-1:0]  ref_div_i,
    input  logic [CNT_W-1:0]  ref_cnt_i,
    input  logic [CNT_W-1:0]  tol_i,
    output logic [TRIM_W-1:0] trim_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              locked_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  meas_cnt_o,
    output logic              meas_valid_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALIGN  = 3'd1,
        S_SETTLE = 3'd2,
        S_MEAS   = 3'd3,
        S_DECIDE = 3'd4,
        S_DONE   = 3'd5,
        S_TRACK  = 3'd6
    } state_t;

    localparam logic [TRIM_W-1:0] TRIM_ONE = TRIM_W'(1);
    localparam logic [TRIM_W-1:0] TRIM_RST = TRIM_ONE << (TRIM_W - 1);
    localparam logic [TRIM_W-1:0] TRIM_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
    localparam logic [1:0]        SETTLE_LD = 2'((SETTLE == 0) ? 0 : SETTLE - 1);
    localparam state_t            S_POSTCHG = (SETTLE == 0) ? S_MEAS : S_SETTLE;

    state_t              state_q;
    logic                ref_meta_q, ref_sync_q, ref_prev_q, ref_edge_q;
    logic [DIV_W-1:0]    win_q;
    logic [CNT_W-1:0]    osc_cnt_q;
    logic [1:0]          settle_q;
    logic [3:0]          bit_q;
    logic                mode_q, track_q;
    logic [DIV_W-1:0]    ref_div_q;
    logic [CNT_W-1:0]    ref_cnt_q, tol_q;
    logic [TRIM_W-1:0]   trim_q;
    logic                busy_q, done_q, locked_q, err_q, meas_valid_q;
    logic [CNT_W-1:0]    meas_cnt_q;

    logic                w_boundary;
    logic [CNT_W-1:0]    w_win_cnt;
    logic [3:0]          w_k;
    logic [TRIM_W-1:0]   w_bit_mask;
    logic                w_keep;
    logic [TRIM_W-1:0]   trim_sar_d;
    logic [CNT_W:0]      w_hi_raw, w_lo_raw;
    logic [CNT_W-1:0]    w_hi, w_lo;
    logic                w_above, w_below, w_step_up, w_step_dn;

    // The first edge in ALIGN always opens a fresh window, whatever win_q holds.
    assign w_boundary = ref_edge_q && ((state_q == S_ALIGN) || (win_q == '0));
    // Report the number of cycles in the window, including the boundary cycle.
    assign w_win_cnt  = (osc_cnt_q == CNT_MAX) ? CNT_MAX : osc_cnt_q + CNT_ONE;
    assign w_k        = ({1'b0, from_msb_i} >= 5'(TRIM_W)) ? 4'(TRIM_W - 1) : from_msb_i;

    assign w_bit_mask = TRIM_ONE << bit_q;
    assign w_keep     = (POL != 0) ? (meas_cnt_q <= ref_cnt_q) : (meas_cnt_q >= ref_cnt_q);
    assign trim_sar_d = (w_keep ? trim_q : (trim_q & ~w_bit_mask)) | (w_bit_mask >> 1);

    assign w_hi_raw   = {1'b0, ref_cnt_q} + {1'b0, tol_q};
    assign w_lo_raw   = {1'b0, ref_cnt_q} - {1'b0, tol_q};
    assign w_hi       = w_hi_raw[CNT_W] ? CNT_MAX : w_hi_raw[CNT_W-1:0];
    assign w_lo       = w_lo_raw[CNT_W] ? '0 : w_lo_raw[CNT_W-1:0];
    assign w_above    = meas_cnt_q > w_hi;
    assign w_below    = meas_cnt_q < w_lo;
    assign w_step_up  = (POL != 0) ? w_below : w_above;
    assign w_step_dn  = (POL != 0) ? w_above : w_below;

    always_ff @(posedge osc_clk or negedge rstb) begin
        if (!rstb) begin
            ref_meta_q <= 1'b0;
            ref_sync_q <= 1'b0;
            ref_prev_q <= 1'b0;
            ref_edge_q <= 1'b0;
            win_q      <= '0;
            osc_cnt_q  <= '0;
        end else begin
            ref_meta_q <= ref_clk_i;
            ref_sync_q <= ref_meta_q;
            ref_prev_q <= ref_sync_q;
            ref_edge_q <= ref_sync_q & ~ref_prev_q;
            if (w_boundary) begin
                win_q <= ref_div_q;
            end else if (ref_edge_q) begin
                win_q <= win_q - DIV_ONE;
            end
            if (w_boundary) begin
                osc_cnt_q <= '0;
            end else if (osc_cnt_q != CNT_MAX) begin
                osc_cnt_q <= osc_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge osc_clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= S_IDLE;
            settle_q     <= '0;
            bit_q        <= '0;
            mode_q       <= 1'b0;
            track_q      <= 1'b0;
            ref_div_q    <= '0;
            ref_cnt_q    <= '0;
            tol_q        <= '0;
            trim_q       <= TRIM_RST;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            meas_cnt_q   <= '0;
            meas_valid_q <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            if (abort_i) begin
                state_q  <= S_IDLE;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
                locked_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start_i) begin
                            mode_q    <= mode_i;
                            track_q   <= 1'b0;
                            ref_div_q <= ref_div_i;
                            ref_cnt_q <= ref_cnt_i;
                            tol_q     <= tol_i;
                            bit_q     <= w_k;
                            trim_q    <= TRIM_ONE << w_k;
                            busy_q    <= 1'b1;
                            done_q    <= 1'b0;
                            locked_q  <= 1'b0;
                            err_q     <= 1'b0;
                            state_q   <= S_ALIGN;
                        end
                    end
                    S_ALIGN: begin
                        if (w_boundary) begin
                            settle_q <= SETTLE_LD;
                            state_q  <= S_POSTCHG;
                        end
                    end
                    S_SETTLE: begin
                        if (w_boundary) begin
                            if (settle_q == 2'd0) begin
                                state_q <= S_MEAS;
                            end else begin
                                settle_q <= settle_q - 2'd1;
                            end
                        end
                    end
                    S_MEAS, S_TRACK: begin
                        if (w_boundary) begin
                            meas_cnt_q   <= w_win_cnt;
                            meas_valid_q <= 1'b1;
                            state_q      <= S_DECIDE;
                        end
                    end
                    S_DECIDE: begin
                        settle_q <= SETTLE_LD;
                        if (!track_q) begin
                            trim_q <= trim_sar_d;
                            if (bit_q != 4'd0) begin
                                bit_q   <= bit_q - 4'd1;
                                state_q <= S_POSTCHG;
                            end else begin
                                done_q <= 1'b1;
                                if (mode_q) begin
                                    track_q <= 1'b1;
                                    state_q <= S_TRACK;
                                end else begin
                                    busy_q  <= 1'b0;
                                    state_q <= S_DONE;
                                end
                            end
                        end else if (w_step_up || w_step_dn) begin
                            locked_q <= 1'b0;
                            // A blocked step at either rail leaves trim alone and flags it.
                            if ((w_step_up && trim_q == TRIM_MAX) ||
                                (w_step_dn && trim_q == '0)) begin
                                err_q   <= 1'b1;
                                state_q <= S_TRACK;
                            end else begin
                                trim_q  <= w_step_up ? trim_q + TRIM_ONE : trim_q - TRIM_ONE;
                                state_q <= S_POSTCHG;
                            end
                        end else begin
                            locked_q <= 1'b1;
                            state_q  <= S_TRACK;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign trim_o       = trim_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign locked_o     = locked_q;
    assign err_o        = err_q;
    assign meas_cnt_o   = meas_cnt_q;
    assign meas_valid_o = meas_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_osc_trim_sar.sv
`default_nettype none
//==============================================================================
// Module   : tb_osc_trim_sar
// Brief    : Directed bench; ref_clk period (in osc cycles) follows a trim model.
// Revision : 1.0
//==============================================================================
module tb_osc_trim_sar;

    logic        osc_clk = 1'b0;
    logic        rstb;
    logic        ref_clk;
    logic        start, abort, mode;
    logic [3:0]  from_msb;
    logic [7:0]  ref_div;
    logic [15:0] ref_cnt, tol;

    logic [7:0]  trim_p, trim_n, trim_c;
    logic        busy_p, done_p, locked_p, err_p, mv_p;
    logic        busy_n, done_n, locked_n, err_n, mv_n;
    logic        busy_c, done_c, locked_c, err_c, mv_c;
    logic [15:0] meas_p, meas_n;
    logic [7:0]  meas_c;

    int n_chk  = 0;
    int n_pass = 0;
    int model_sel   = 0;
    int model_off   = 50;
    int model_const = 32;
    int mv_total    = 0;
    logic [7:0] seq [256];
    logic [7:0] exp_seq [8] = '{8'h80, 8'h40, 8'h60, 8'h70, 8'h68, 8'h64, 8'h66, 8'h65};

    always #5 osc_clk = ~osc_clk;

    osc_trim_sar #(.TRIM_W(8), .CNT_W(16), .DIV_W(8), .POL(1), .SETTLE(0)) u_dut (
        .osc_clk(osc_clk), .rstb(rstb), .ref_clk_i(ref_clk), .start_i(start), .abort_i(abort),
        .mode_i(mode), .from_msb_i(from_msb), .ref_div_i(ref_div), .ref_cnt_i(ref_cnt), .tol_i(tol),
        .trim_o(trim_p), .busy_o(busy_p), .done_o(done_p), .locked_o(locked_p), .err_o(err_p),
        .meas_cnt_o(meas_p), .meas_valid_o(mv_p));

    osc_trim_sar #(.TRIM_W(8), .CNT_W(16), .DIV_W(8), .POL(0), .SETTLE(0)) u_dut_n (
        .osc_clk(osc_clk), .rstb(rstb), .ref_clk_i(ref_clk), .start_i(start), .abort_i(abort),
        .mode_i(mode), .from_msb_i(from_msb), .ref_div_i(ref_div), .ref_cnt_i(ref_cnt), .tol_i(tol),
        .trim_o(trim_n), .busy_o(busy_n), .done_o(done_n), .locked_o(locked_n), .err_o(err_n),
        .meas_cnt_o(meas_n), .meas_valid_o(mv_n));

    osc_trim_sar #(.TRIM_W(8), .CNT_W(8), .DIV_W(8), .POL(1), .SETTLE(1)) u_dut_c8 (
        .osc_clk(osc_clk), .rstb(rstb), .ref_clk_i(ref_clk), .start_i(start), .abort_i(abort),
        .mode_i(mode), .from_msb_i(from_msb), .ref_div_i(ref_div), .ref_cnt_i(ref_cnt[7:0]),
        .tol_i(tol[7:0]), .trim_o(trim_c), .busy_o(busy_c), .done_o(done_c), .locked_o(locked_c),
        .err_o(err_c), .meas_cnt_o(meas_c), .meas_valid_o(mv_c));

    function automatic int model_n();
        case (model_sel)
            0:       return 2 * int'(trim_p) + model_off;
            1:       return 560 - 2 * int'(trim_n);
            default: return model_const;
        endcase
    endfunction

    // Next ref period is chosen once the DUT has had time to apply a trim decision.
    initial begin
        int n;
        ref_clk = 1'b0;
        forever begin
            @(negedge osc_clk);
            ref_clk = 1'b1;
            repeat (8) @(negedge osc_clk);
            n = model_n();
            repeat (n / 2 - 8) @(negedge osc_clk);
            ref_clk = 1'b0;
            repeat (n - n / 2 - 1) @(negedge osc_clk);
        end
    end

    always @(negedge osc_clk) begin
        if (mv_p) begin
            seq[mv_total % 256] = trim_p;
            mv_total = mv_total + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic cond(input int id);
        case (id)
            0:       return done_p;
            1:       return done_n;
            2:       return done_c;
            3:       return locked_p;
            4:       return !locked_p;
            5:       return err_p;
            6:       return trim_p == 8'h70;
            default: return mv_p;
        endcase
    endfunction

    task automatic wait_until(input int id, input int budget, input string tag);
        logic reached = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cond(id)) begin
                reached = 1'b1;
                break;
            end
            @(negedge osc_clk);
        end
        check_eq({tag, "_reached"}, 32'(reached), 32'd1);
    endtask

    task automatic pulse_abort();
        @(negedge osc_clk); abort = 1'b1;
        @(negedge osc_clk); abort = 1'b0;
    endtask

    task automatic run(input logic m, input logic [3:0] fm, input logic [7:0] div);
        pulse_abort();
        mode = m; from_msb = fm; ref_div = div;
        @(negedge osc_clk); start = 1'b1;
        @(negedge osc_clk); start = 1'b0;
    endtask

    initial begin
        int base;
        rstb = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
        from_msb = 4'd7; ref_div = 8'd0; ref_cnt = 16'd250; tol = 16'd3;
        repeat (3) @(negedge osc_clk);
        check_eq("rst_trim", trim_p, 8'h80);
        check_eq("rst_busy", busy_p, 1'b0);
        check_eq("rst_done", done_p, 1'b0);
        check_eq("rst_locked", locked_p, 1'b0);
        check_eq("rst_err", err_p, 1'b0);
        check_eq("rst_meas", meas_p, 16'd0);
        check_eq("rst_mvalid", mv_p, 1'b0);
        rstb = 1'b1;

        // One-shot SAR, POL=1, N = 2*trim+50
        model_sel = 0; model_off = 50;
        base = mv_total;
        run(1'b0, 4'd7, 8'd0);
        wait_until(0, 20000, "sar_done");
        check_eq("sar_trim", trim_p, 8'h64);
        check_eq("sar_done", done_p, 1'b1);
        check_eq("sar_busy", busy_p, 1'b0);
        check_eq("sar_pulses", mv_total - base, 8);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("sar_seq%0d", i), seq[(base + i) % 256], exp_seq[i]);

        // from_msb beyond TRIM_W clamps to bit 7
        run(1'b0, 4'd12, 8'd0);
        check_eq("clamp_trim", trim_p, 8'h80);
        check_eq("clamp_busy", busy_p, 1'b1);

        // POL=0 with N = 560-2*trim
        model_sel = 1;
        run(1'b0, 4'd7, 8'd0);
        wait_until(1, 20000, "pol0_done");
        check_eq("pol0_trim", trim_n, 8'h9B);

        // Tracking: lock at 0x64, then model shift walks trim down to 0x60 (N=252)
        model_sel = 0; model_off = 50;
        run(1'b1, 4'd7, 8'd0);
        wait_until(3, 20000, "trk_lock");
        check_eq("trk_trim0", trim_p, 8'h64);
        check_eq("trk_done", done_p, 1'b1);
        check_eq("trk_busy", busy_p, 1'b1);
        model_off = 60;
        wait_until(4, 5000, "trk_unlock");
        wait_until(3, 10000, "trk_relock");
        check_eq("trk_trim1", trim_p, 8'h60);
        check_eq("trk_err", err_p, 1'b0);

        // Saturation at code 0
        model_sel = 2; model_const = 1000;
        run(1'b1, 4'd7, 8'd0);
        wait_until(5, 30000, "sat_err");
        check_eq("sat_trim", trim_p, 8'h00);
        check_eq("sat_locked", locked_p, 1'b0);
        for (int i = 0; i < 2; i++) begin
            wait_until(7, 3000, "sat_win");
            @(negedge osc_clk);
        end
        check_eq("sat_trim_hold", trim_p, 8'h00);
        pulse_abort();
        check_eq("abort_err_held", err_p, 1'b1);
        check_eq("abort_busy", busy_p, 1'b0);
        run(1'b0, 4'd7, 8'd0);
        check_eq("start_clr_err", err_p, 1'b0);

        // abort during bit-4 measurement, then start+abort together
        model_sel = 0; model_off = 50;
        run(1'b0, 4'd7, 8'd0);
        wait_until(6, 5000, "ab_bit4");
        repeat (5) @(negedge osc_clk);
        abort = 1'b1;
        @(negedge osc_clk); abort = 1'b0;
        check_eq("ab_busy", busy_p, 1'b0);
        check_eq("ab_done", done_p, 1'b0);
        check_eq("ab_trim", trim_p, 8'h70);
        start = 1'b1; abort = 1'b1;
        @(negedge osc_clk); start = 1'b0; abort = 1'b0;
        check_eq("sa_busy", busy_p, 1'b0);
        check_eq("sa_trim", trim_p, 8'h70);

        // Window length: osc = 32x ref
        model_sel = 2; model_const = 32;
        run(1'b0, 4'd0, 8'd0);
        wait_until(0, 2000, "div0_done");
        check_eq("div0_meas", meas_p, 16'd32);
        run(1'b0, 4'd0, 8'd255);
        wait_until(0, 20000, "div255_done");
        check_eq("div255_meas", meas_p, 16'd8192);
        wait_until(2, 30000, "c8_done");
        check_eq("c8_sat_meas", meas_c, 8'hFF);

        // Asynchronous reset mid-run
        model_sel = 0;
        run(1'b0, 4'd7, 8'd0);
        repeat (200) @(negedge osc_clk);
        rstb = 1'b0;
        #1;
        check_eq("arst_trim", trim_p, 8'h80);
        check_eq("arst_busy", busy_p, 1'b0);
        check_eq("arst_meas", meas_p, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
